fetch_instr_queue: RTL and testbench

Instruction queue between the fetch stage's instruction selector and the decode/issue stage. Each cycle it accepts at most one 32-bit instruction with its PC, branch-prediction info and fetch-exception flag. It buffers up to DEPTH entries in order and presents the oldest to decode over a valid/ready handshake. It decouples icache line stalls from decode back-pressure and is flushed on pipeline redirects.

---
 rtl/len5_pkg.sv | 17 +
 rtl/fetch_instr_queue.sv | 105 ++++++++++
 tb/tb_fetch_instr_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/len5_pkg.sv
// Shared widths and bus payload types for the len5 front end.
// The instruction queue entry and its default depth live here.
package len5_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned IQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            except;
  } iq_entry_t;

endpackage

// File: rtl/fetch_instr_queue.sv
// In-order instruction queue between fetch selector and decode/issue.
// Optional same-cycle empty-queue pass-through when LEN5_IQ_BYPASS_EN is defined.
module fetch_instr_queue
  import len5_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          fetch_valid_i,
  output logic                          fetch_ready_o,
  input  logic [XLEN-1:0]               fetch_pc_i,
  input  logic [ILEN-1:0]               fetch_instr_i,
  input  logic                          fetch_pred_taken_i,
  input  logic [XLEN-1:0]               fetch_pred_target_i,
  input  logic                          fetch_except_i,
  output logic                          issue_valid_o,
  input  logic                          issue_ready_i,
  output logic [XLEN-1:0]               issue_pc_o,
  output logic [ILEN-1:0]               issue_instr_o,
  output logic                          issue_pred_taken_o,
  output logic [XLEN-1:0]               issue_pred_target_o,
  output logic                          issue_except_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  iq_entry_t              r_mem [DEPTH];
  logic      [PTR_W-1:0]  r_head;
  logic      [PTR_W-1:0]  r_tail;
  logic      [CNT_W-1:0]  r_count;

  iq_entry_t              w_in;
  iq_entry_t              w_head;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_rd;

  assign w_in = '{pc:          fetch_pc_i,
                  instr:       fetch_instr_i,
                  pred_taken:  fetch_pred_taken_i,
                  pred_target: fetch_pred_target_i,
                  except:      fetch_except_i};

  assign w_empty       = (r_count == '0);
  assign fetch_ready_o = (r_count < CNT_W'(DEPTH));

`ifdef LEN5_IQ_BYPASS_EN
  // Empty queue forwards the offered entry straight to decode.
  assign issue_valid_o = (!w_empty || fetch_valid_i) && !flush_i;
  assign w_head        = w_empty ? w_in : r_mem[r_head];
`else
  assign issue_valid_o = !w_empty && !flush_i;
  assign w_head        = r_mem[r_head];
`endif

  assign w_push = fetch_valid_i && fetch_ready_o;
  assign w_pop  = issue_valid_o && issue_ready_i;

  // A pop from an empty queue can only be a pass-through: nothing stored, nothing read.
  assign w_wr = w_push && !(w_empty && w_pop);
  assign w_rd = w_pop && !w_empty;

  assign issue_pc_o          = w_head.pc;
  assign issue_instr_o       = w_head.instr;
  assign issue_pred_taken_o  = w_head.pred_taken;
  assign issue_pred_target_o = w_head.pred_target;
  assign issue_except_o      = w_head.except;
  assign count_o             = r_count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + PTR_W'(1);
      if (w_rd) r_head <= r_head + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not cleared by flush; pointers alone define occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr && !flush_i) begin
      r_mem[r_tail] <= w_in;
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Self-checking bench for fetch_instr_queue against a queue-based reference model.
// Bypass expectations follow LEN5_IQ_BYPASS_EN when it is defined for the build.
module tb_fetch_instr_queue;
  import len5_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef LEN5_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              fv;
  logic              fr;
  logic [XLEN-1:0]   fpc;
  logic [ILEN-1:0]   finstr;
  logic              fpt;
  logic [XLEN-1:0]   ftgt;
  logic              fexc;
  logic              iv;
  logic              ir;
  logic [XLEN-1:0]   ipc;
  logic [ILEN-1:0]   iinstr;
  logic              ipt;
  logic [XLEN-1:0]   itgt;
  logic              iexc;
  logic [2:0]        cnt;

  int total = 0;
  int bad   = 0;
  iq_entry_t q[$];

  always #5 clk = ~clk;

  fetch_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .fetch_valid_i(fv), .fetch_ready_o(fr),
    .fetch_pc_i(fpc), .fetch_instr_i(finstr),
    .fetch_pred_taken_i(fpt), .fetch_pred_target_i(ftgt), .fetch_except_i(fexc),
    .issue_valid_o(iv), .issue_ready_i(ir),
    .issue_pc_o(ipc), .issue_instr_o(iinstr),
    .issue_pred_taken_o(ipt), .issue_pred_target_o(itgt), .issue_except_o(iexc),
    .count_o(cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational view at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic r, input logic fl);
    iq_entry_t e, hd;
    int        sz;
    bit        byp, exp_v, push, pop;
    e.pc          = pc;
    e.instr       = $urandom;
    e.pred_taken  = 1'($urandom);
    e.pred_target = $urandom;
    e.except      = 1'($urandom);
    fv = v; fpc = e.pc; finstr = e.instr; fpt = e.pred_taken;
    ftgt = e.pred_target; fexc = e.except; ir = r; flush = fl;
    @(negedge clk);
    sz    = q.size();
    byp   = BYP && (sz == 0) && v;
    exp_v = ((sz != 0) || byp) && !fl;
    check("count", 64'(cnt), 64'(sz));
    check("fetch_ready", 64'(fr), 64'(sz < DEPTH));
    check("issue_valid", 64'(iv), 64'(exp_v));
    if (exp_v) begin
      hd = byp ? e : q[0];
      check("issue_pc", 64'(ipc), 64'(hd.pc));
      check("issue_instr", 64'(iinstr), 64'(hd.instr));
      check("issue_pred_taken", 64'(ipt), 64'(hd.pred_taken));
      check("issue_pred_target", 64'(itgt), 64'(hd.pred_target));
      check("issue_except", 64'(iexc), 64'(hd.except));
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      push = v && (sz < DEPTH);
      pop  = exp_v && r;
      if (!(pop && sz == 0)) begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fv = 1'b0; ir = 1'b0;
    fpc = '0; finstr = '0; fpt = 1'b0; ftgt = '0; fexc = 1'b0;

    // Reset for 3 cycles, all outputs quiet and data reads zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", 64'(cnt), 64'd0);
    check("rst_ready", 64'(fr), 64'd1);
    check("rst_valid", 64'(iv), 64'd0);
    check("rst_pc", 64'(ipc), 64'd0);
    check("rst_instr", 64'(iinstr), 64'd0);
    check("rst_target", 64'(itgt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill to full, then a fifth offer is refused.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'h110, 1'b0, 1'b0);
    check("full_count", 64'(cnt), 64'd4);
    check("full_ready", 64'(fr), 64'd0);

    // Drain in order, then empty.
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(ipc), 64'(32'h100 + 32'(4 * i)));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Steady push+pop at count 2, pointers wrap.
    step(1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h308 + 32'(4 * i), 1'b1, 1'b0);
    check("steady_count", 64'(cnt), 64'd2);

    // Flush with 3 queued plus simultaneous push and pop.
    step(1'b1, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h4FC, 1'b1, 1'b1);
    check("post_flush_count", 64'(cnt), 64'd0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Empty-queue push with decode ready: same cycle under bypass, else one cycle later.
    step(1'b1, 32'h200, 1'b1, 1'b0);
    check("byp_count", 64'(cnt), BYP ? 64'd0 : 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h204, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom_range(0, 31) == 0));

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
    fv = 1'b0; ir = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(cnt), 64'd0);
    check("async_rst_valid", 64'(iv), 64'd0);
    q.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(4 * i), 1'b1, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
